// File: rtl/stream_rr_arb.sv
// Purpose : N-way round-robin arbiter feeding one registered valid/ready output stage.
// Latency : 1 cycle from an accepted input beat to o_vld; one beat per cycle under continuous i_rdy.
// Backpres: o_rdy is the grant qualified by (!o_vld | i_rdy); a stalled output freezes ptr, lock and output regs.
//
// Ports:
//   clk, arst_n            clock, asynchronous active-low reset
//   i_vld/i_dat/i_last     per-requester beat (N lanes, W-bit payload + end-of-packet)
//   o_rdy                  per-requester ready, at most one bit set
//   o_vld/o_dat/o_last     registered output beat
//   o_sel                  registered one-hot source of the output beat
//   i_rdy                  downstream ready
//
// Optional feature macro: STREAM_RR_ARB_PKT_LOCK_EN
//   defined   -> packet lock: once a multi-beat packet starts, its owner keeps the
//                channel until its last beat is accepted.
//   undefined -> every beat is an arbitration point; i_last is only forwarded.

// Generic one-hot AND-OR selector.
// Latency : combinational.
// Backpres: none; pure datapath.
module onehot_mux #(
  parameter int N = 4,
  parameter int W = 33
) (
  input  logic [N-1:0]        sel,
  input  logic [N-1:0][W-1:0] din,
  output logic [W-1:0]        dout
);

  always_comb begin
    dout = '0;
    for (int k = 0; k < N; k++) begin
      dout = dout | (din[k] & {W{sel[k]}});
    end
  end

endmodule

module stream_rr_arb #(
  parameter int N = 4,
  parameter int W = 32
) (
  input  logic                clk,
  input  logic                arst_n,
  input  logic [N-1:0]        i_vld,
  input  logic [N-1:0][W-1:0] i_dat,
  input  logic [N-1:0]        i_last,
  output logic [N-1:0]        o_rdy,
  output logic                o_vld,
  output logic [W-1:0]        o_dat,
  output logic                o_last,
  output logic [N-1:0]        o_sel,
  input  logic                i_rdy
);

  typedef struct packed {
    logic         last;
    logic [W-1:0] dat;
  } beat_t;

  logic [N-1:0]      ptr;
  logic [N-1:0]      gnt_rr;
  logic [N-1:0]      gnt;
  logic [N-1:0]      gnt_rot;
  logic [N-1:0][W:0] beat_in;
  beat_t             beat_sel;
  logic              can_acc;
  logic              accept;
  logic              found;
  int                idx;

  // The output register can take a new beat when empty or when its current
  // beat leaves this cycle; this is what gives back-to-back throughput.
  assign can_acc = !o_vld || i_rdy;

  // Round-robin search starting at the one-hot ptr position and wrapping.
  // ptr is always one-hot, so only one outer iteration contributes.
  always_comb begin
    gnt_rr = '0;
    found  = 1'b0;
    idx    = 0;
    for (int s = 0; s < N; s++) begin
      if (ptr[s]) begin
        for (int o = 0; o < N; o++) begin
          idx = s + o;
          if (idx >= N) idx = idx - N;
          if (!found && i_vld[idx]) begin
            gnt_rr[idx] = 1'b1;
            found       = 1'b1;
          end
        end
      end
    end
  end

`ifdef STREAM_RR_ARB_PKT_LOCK_EN
  typedef enum logic {
    IDLE,
    LOCKED
  } lock_state_t;

  lock_state_t  lock_state;
  logic [N-1:0] owner;

  // While a packet is in flight only its owner may transfer, even if it
  // momentarily drops valid; everyone else waits for the last beat.
  assign gnt = (lock_state == LOCKED) ? (owner & i_vld) : gnt_rr;
`else
  assign gnt = gnt_rr;
`endif

  // Gating with arst_n keeps every ready low while reset is held.
  assign o_rdy   = gnt & {N{can_acc}} & {N{arst_n}};
  assign accept  = |(i_vld & o_rdy);
  assign gnt_rot = {gnt[N-2:0], gnt[N-1]};

  always_comb begin
    beat_in = '0;
    for (int k = 0; k < N; k++) begin
      beat_in[k] = {i_last[k], i_dat[k]};
    end
  end

  onehot_mux #(
    .N (N),
    .W (W + 1)
  ) u_mux (
    .sel  (gnt),
    .din  (beat_in),
    .dout (beat_sel)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      o_vld      <= 1'b0;
      o_dat      <= '0;
      o_last     <= 1'b0;
      o_sel      <= '0;
      ptr        <= {{(N-1){1'b0}}, 1'b1};
`ifdef STREAM_RR_ARB_PKT_LOCK_EN
      lock_state <= IDLE;
      owner      <= '0;
`endif
    end else begin
      // Output stage: a new beat overwrites a departing one with no bubble.
      if (accept) begin
        o_vld  <= 1'b1;
        o_dat  <= beat_sel.dat;
        o_last <= beat_sel.last;
        o_sel  <= gnt;
      end else if (i_rdy) begin
        o_vld  <= 1'b0;
      end

`ifdef STREAM_RR_ARB_PKT_LOCK_EN
      // ptr moves only at packet boundaries. In LOCKED, gnt equals owner on
      // an accept, so rotating gnt is rotating owner.
      if (accept) begin
        if (lock_state == IDLE) begin
          if (!beat_sel.last) begin
            lock_state <= LOCKED;
            owner      <= gnt;
          end else begin
            ptr        <= gnt_rot;
          end
        end else begin
          if (beat_sel.last) begin
            lock_state <= IDLE;
            ptr        <= gnt_rot;
          end
        end
      end
`else
      if (accept) begin
        ptr <= gnt_rot;
      end
`endif
    end
  end

endmodule

// File: tb/tb_stream_rr_arb.sv
module tb_stream_rr_arb;

  localparam int N = 4;
  localparam int W = 32;

  logic                clk = 1'b0;
  logic                arst_n;
  logic [N-1:0]        i_vld;
  logic [N-1:0][W-1:0] i_dat;
  logic [N-1:0]        i_last;
  logic [N-1:0]        o_rdy;
  logic                o_vld;
  logic [W-1:0]        o_dat;
  logic                o_last;
  logic [N-1:0]        o_sel;
  logic                i_rdy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stream_rr_arb #(.N(N), .W(W)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .i_vld  (i_vld),
    .i_dat  (i_dat),
    .i_last (i_last),
    .o_rdy  (o_rdy),
    .o_vld  (o_vld),
    .o_dat  (o_dat),
    .o_last (o_last),
    .o_sel  (o_sel),
    .i_rdy  (i_rdy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    arst_n = 1'b0;
    i_vld  = '0;
    i_dat  = '0;
    i_last = '0;
    i_rdy  = 1'b1;
    tick();
    tick();
    arst_n = 1'b1;
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    i_vld  = '1;
    i_last = '1;
    i_dat  = '0;
    i_rdy  = 1'b1;
    #3;
    checks++;
    if (o_rdy !== 4'b0000) begin
      errors++; $display("FAIL reset_held_o_rdy: got %b expected 0000", o_rdy);
    end
    checks++;
    if (o_vld !== 1'b0) begin
      errors++; $display("FAIL reset_held_o_vld: got %b expected 0", o_vld);
    end
    tick();
    i_vld  = '0;
    arst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (o_vld !== 1'b0) begin
        errors++; $display("FAIL reset_idle_o_vld cyc %0d: got %b expected 0", c, o_vld);
      end
      checks++;
      if (o_rdy !== 4'b0000) begin
        errors++; $display("FAIL reset_idle_o_rdy cyc %0d: got %b expected 0000", c, o_rdy);
      end
      checks++;
      if (o_sel !== 4'b0000) begin
        errors++; $display("FAIL reset_idle_o_sel cyc %0d: got %b expected 0000", c, o_sel);
      end
    end
  endtask

  task automatic test_fairness();
    logic [N-1:0] exp_sel;
    logic [W-1:0] exp_dat;
    do_reset();
    for (int k = 0; k < N; k++) i_dat[k] = 32'h10 + k;
    i_last = '1;
    i_vld  = '1;
    i_rdy  = 1'b1;
    #1;
    checks++;
    if (o_rdy !== 4'b0001) begin
      errors++; $display("FAIL fair_first_o_rdy: got %b expected 0001", o_rdy);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      exp_sel = 4'b0001 << (i % 4);
      exp_dat = 32'h10 + (i % 4);
      checks++;
      if (o_vld !== 1'b1) begin
        errors++; $display("FAIL fair_o_vld beat %0d: got %b expected 1", i, o_vld);
      end
      checks++;
      if (o_dat !== exp_dat) begin
        errors++; $display("FAIL fair_o_dat beat %0d: got %h expected %h", i, o_dat, exp_dat);
      end
      checks++;
      if (o_sel !== exp_sel) begin
        errors++; $display("FAIL fair_o_sel beat %0d: got %b expected %b", i, o_sel, exp_sel);
      end
    end
    i_vld = '0;
    tick();
    checks++;
    if (o_vld !== 1'b0) begin
      errors++; $display("FAIL fair_drain_o_vld: got %b expected 0", o_vld);
    end
  endtask

  task automatic test_stall();
    do_reset();
    i_dat[0] = 32'hA0;
    i_dat[2] = 32'hA2;
    i_last   = '1;
    i_vld    = 4'b0101;
    i_rdy    = 1'b0;
    #1;
    checks++;
    if (o_rdy !== 4'b0001) begin
      errors++; $display("FAIL stall_first_o_rdy: got %b expected 0001", o_rdy);
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (o_rdy !== 4'b0000) begin
        errors++; $display("FAIL stall_o_rdy cyc %0d: got %b expected 0000", c, o_rdy);
      end
      checks++;
      if (o_vld !== 1'b1 || o_dat !== 32'hA0 || o_sel !== 4'b0001) begin
        errors++;
        $display("FAIL stall_hold cyc %0d: got vld=%b dat=%h sel=%b expected vld=1 dat=a0 sel=0001",
                 c, o_vld, o_dat, o_sel);
      end
    end
    i_rdy = 1'b1;
    #1;
    checks++;
    if (o_rdy !== 4'b0100) begin
      errors++; $display("FAIL stall_release_o_rdy: got %b expected 0100", o_rdy);
    end
    tick();
    checks++;
    if (o_vld !== 1'b1 || o_dat !== 32'hA2 || o_sel !== 4'b0100) begin
      errors++;
      $display("FAIL stall_next_beat: got vld=%b dat=%h sel=%b expected vld=1 dat=a2 sel=0100",
               o_vld, o_dat, o_sel);
    end
    checks++;
    if (o_rdy !== 4'b0001) begin
      errors++; $display("FAIL stall_wrap_o_rdy: got %b expected 0001", o_rdy);
    end
  endtask

  // Requester 1 sends a 3-beat packet while 0 and 3 keep single-beat traffic up.
  task automatic test_packet();
    logic [N-1:0] exp_g [4];
    logic [W-1:0] exp_dat;
    logic         exp_last;
    int           b1;
`ifdef STREAM_RR_ARB_PKT_LOCK_EN
    exp_g[0] = 4'b0010; exp_g[1] = 4'b0010; exp_g[2] = 4'b0010; exp_g[3] = 4'b1000;
`else
    exp_g[0] = 4'b0010; exp_g[1] = 4'b1000; exp_g[2] = 4'b0001; exp_g[3] = 4'b0010;
`endif
    do_reset();
    // A lone single-beat packet from requester 0 moves ptr to requester 1.
    i_rdy    = 1'b1;
    i_last   = '1;
    i_dat[0] = 32'h30;
    i_vld    = 4'b0001;
    tick();
    b1        = 0;
    i_dat[1]  = 32'h20;
    i_dat[3]  = 32'h33;
    i_last[1] = 1'b0;
    i_vld     = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (o_rdy !== exp_g[i]) begin
        errors++; $display("FAIL pkt_o_rdy grant %0d: got %b expected %b", i, o_rdy, exp_g[i]);
      end
      tick();
      if (exp_g[i] == 4'b0010) begin
        exp_dat  = 32'h20 + b1;
        exp_last = (b1 == 2);
      end else if (exp_g[i] == 4'b0001) begin
        exp_dat  = 32'h30;
        exp_last = 1'b1;
      end else begin
        exp_dat  = 32'h33;
        exp_last = 1'b1;
      end
      checks++;
      if (o_sel !== exp_g[i] || o_vld !== 1'b1) begin
        errors++; $display("FAIL pkt_o_sel beat %0d: got sel=%b vld=%b expected sel=%b vld=1",
                           i, o_sel, o_vld, exp_g[i]);
      end
      checks++;
      if (o_dat !== exp_dat || o_last !== exp_last) begin
        errors++; $display("FAIL pkt_o_dat beat %0d: got dat=%h last=%b expected dat=%h last=%b",
                           i, o_dat, o_last, exp_dat, exp_last);
      end
      if (exp_g[i] == 4'b0010) begin
        b1++;
        i_dat[1]  = 32'h20 + b1;
        i_last[1] = (b1 == 2);
        if (b1 == 3) i_vld[1] = 1'b0;
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    i_rdy    = 1'b1;
    i_last   = '1;
    i_dat[0] = 32'h40;
    i_vld    = 4'b0001;
    tick();
    i_dat[1]  = 32'h41;
    i_last[1] = 1'b0;
    i_vld     = 4'b0010;
    tick();
    // Packet from requester 1 is open and its first beat sits in the output.
    i_rdy    = 1'b0;
    i_dat[1] = 32'h42;
    #1;
    checks++;
    if (o_vld !== 1'b1 || o_dat !== 32'h41) begin
      errors++; $display("FAIL arst_pre: got vld=%b dat=%h expected vld=1 dat=41", o_vld, o_dat);
    end
    #2;
    arst_n = 1'b0;
    #1;
    checks++;
    if (o_vld !== 1'b0 || o_sel !== 4'b0000 || o_dat !== 32'h0) begin
      errors++; $display("FAIL arst_clear: got vld=%b sel=%b dat=%h expected vld=0 sel=0000 dat=0",
                         o_vld, o_sel, o_dat);
    end
    checks++;
    if (o_rdy !== 4'b0000) begin
      errors++; $display("FAIL arst_o_rdy: got %b expected 0000", o_rdy);
    end
    i_vld  = 4'b1001;
    i_last = '1;
    i_dat[0] = 32'h50;
    i_rdy  = 1'b1;
    #1;
    arst_n = 1'b1;
    #1;
    checks++;
    if (o_rdy !== 4'b0001) begin
      errors++; $display("FAIL arst_restart_o_rdy: got %b expected 0001", o_rdy);
    end
    tick();
    checks++;
    if (o_sel !== 4'b0001 || o_dat !== 32'h50) begin
      errors++; $display("FAIL arst_restart_beat: got sel=%b dat=%h expected sel=0001 dat=50",
                         o_sel, o_dat);
    end
  endtask

  initial begin
    arst_n = 1'b0;
    i_vld  = '0;
    i_dat  = '0;
    i_last = '0;
    i_rdy  = 1'b1;
    test_reset();
    test_fairness();
    test_stall();
    test_packet();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
